imm_gen: RTL and testbench

//  RV32I immediate generator in the decode stage. Reassembles and sign-extends
//  the immediate field of the current instruction into 32 bits, per the format

---
 rtl/imm_gen_if.sv | 9 +
 rtl/imm_gen.sv | 59 +++++
 tb/tb_imm_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/imm_gen_if.sv
// Decode-stage immediate bus: format select and instruction bits in, assembled immediate out.
interface imm_gen_if;
  logic [2:0]  imm_sel;
  logic [31:7] inst;
  logic [31:0] imm;

  modport master (output imm_sel, output inst, input imm);
  modport slave  (input imm_sel, input inst, output imm);
endinterface

// File: rtl/imm_gen.sv
// RV32I immediate generator: reassembles and sign-extends the instruction immediate.
// Define IMMGEN_REG_OUT_EN to register the output (1-cycle latency, async clear on rst_n).
module imm_gen (
  input  logic      clk,
  input  logic      rst_n,
  imm_gen_if.slave  bus
);

  typedef enum logic [2:0] {
    SEL_I = 3'b000,
    SEL_S = 3'b001,
    SEL_B = 3'b010,
    SEL_U = 3'b011,
    SEL_J = 3'b100,
    SEL_Z = 3'b101
  } imm_sel_e;

  logic        sign;
  logic [31:0] imm_d;

  assign sign = bus.inst[31];

  // Unknown or reserved selects fall to the default and produce zero.
  always_comb begin
    imm_d = 32'h0000_0000;
    case (bus.imm_sel)
      SEL_I: imm_d = {{20{sign}}, bus.inst[31:20]};
      SEL_S: imm_d = {{20{sign}}, bus.inst[31:25], bus.inst[11:7]};
      SEL_B: imm_d = {{19{sign}}, sign, bus.inst[7], bus.inst[30:25],
                      bus.inst[11:8], 1'b0};
      SEL_U: imm_d = {bus.inst[31:12], 12'h000};
      SEL_J: imm_d = {{11{sign}}, sign, bus.inst[19:12], bus.inst[20],
                      bus.inst[30:21], 1'b0};
      SEL_Z: imm_d = {27'b0, bus.inst[19:15]};
      default: imm_d = 32'h0000_0000;
    endcase
  end

`ifdef IMMGEN_REG_OUT_EN
  logic [31:0] imm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_q <= 32'h0000_0000;
    end else begin
      imm_q <= imm_d;
    end
  end

  assign bus.imm = imm_q;
`else
  // Clock and reset are only needed by the registered build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign bus.imm = imm_d;
`endif

endmodule

// File: tb/tb_imm_gen.sv
// Directed-vector bench for imm_gen; covers both the combinational and registered builds.
module tb_imm_gen;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  imm_gen_if bus ();

  imm_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] sel, input logic [31:0] ins);
    logic [31:0] word;
    word        = ins;
    bus.imm_sel = sel;
    bus.inst    = word[31:7];
  endtask

  task automatic apply(input string tag, input logic [2:0] sel, input logic [31:0] ins,
                       input logic [31:0] exp);
    @(negedge clk);
    drive(sel, ins);
`ifdef IMMGEN_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
    check(tag, bus.imm, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(3'b000, 32'hFFF0_0093);
    #3;
`ifdef IMMGEN_REG_OUT_EN
    check("reset_clear", bus.imm, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("reset_hold", bus.imm, 32'h0000_0000);
`else
    check("reset_no_effect", bus.imm, 32'hFFFF_FFFF);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    apply("I_neg",      3'b000, 32'hFFF0_0093, 32'hFFFF_FFFF);
    apply("I_pos",      3'b000, 32'h7FF0_0013, 32'h0000_07FF);
    apply("S_pos",      3'b001, 32'h0020_A423, 32'h0000_0008);
    apply("S_neg",      3'b001, 32'hFE00_0FA3, 32'hFFFF_FFFF);
    apply("B_neg",      3'b010, 32'hFE00_0EE3, 32'hFFFF_FFFC);
    apply("B_pos",      3'b010, 32'h7E00_0FE3, 32'h0000_0FFE);
    apply("U_pos",      3'b011, 32'h1234_50B7, 32'h1234_5000);
    apply("U_top",      3'b011, 32'hFFFF_F037, 32'hFFFF_F000);
    apply("J_neg",      3'b100, 32'hFF9F_F06F, 32'hFFFF_FFF8);
    apply("J_pos",      3'b100, 32'h7FFF_F06F, 32'h000F_FFFE);
    apply("Z_max",      3'b101, 32'h000F_8073, 32'h0000_001F);
    apply("Z_no_sext",  3'b101, 32'h800F_8073, 32'h0000_001F);
    apply("rsv_110",    3'b110, 32'hFFFF_FFFF, 32'h0000_0000);
    apply("rsv_111",    3'b111, 32'hFFFF_FFFF, 32'h0000_0000);

`ifdef IMMGEN_REG_OUT_EN
    // Output must still show the previous value until the next capture edge.
    @(negedge clk);
    drive(3'b011, 32'h1234_50B7);
    #1;
    check("latency_hold", bus.imm, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("latency_update", bus.imm, 32'h1234_5000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", bus.imm, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("clear_held", bus.imm, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_capture", bus.imm, 32'h1234_5000);
`else
    drive(3'b011, 32'h1234_50B7);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_ignored", bus.imm, 32'h1234_5000);
    rst_n = 1'b1;
    drive(3'b000, 32'h0010_0013);
    #1;
    check("zero_latency", bus.imm, 32'h0000_0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
